mmem_port: RTL and testbench
============================

# mmem_port

M scratchpad memory port: a 32-word × 32-bit store sitting directly downstream of the M-memory control stage. It consumes `madr`, `mrp` and `mwp`, and captures write data from the L bus. It delivers the registered read word that feeds the M latch and the ALU M-side. It zero-fills itself after reset, stages every write through a one-entry pending register, and forwards pending data to reads of the same address.

## Interface
Parameters:
- `AW`, 5: address width (32 words).
- `DW`, 32: data width.

Ports:
- `clk`  in  1  processor clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `madr`  in  AW  M-memory address; read address in decode state, write address in write state.
- `mrp`  in  1  M read pulse (decode state).
- `mwp`  in  1  M write pulse (write state with M destination).
- `l`  in  DW  write data (L register).
- `mmem`  out  DW  registered read word.
- `init_busy`  out  1  high while the post-reset zero-fill sweep runs.

## Operation
- FSM states: INIT, RUN.
- While `reset_n`=0, all of the following hold:
  - state forced to INIT;
  - sweep counter = 0;
  - `pend_valid` = 0;
  - `mmem` = 0;
  - `init_busy` = 1.
- INIT:
  - Each clock writes 0 to array[sweep_cnt], then increments `sweep_cnt`.
  - After the write to address 31, the next state is RUN and `init_busy` drops.
  - INIT lasts exactly 32 cycles after reset release.
  - `mrp`/`mwp` are ignored in INIT: no pending capture, and `mmem` stays 0.
- RUN, write path:
  - On an edge with `mwp`=1, capture {`madr`, `l`} into the pending register and set `pend_valid`=1.
  - On an edge with `pend_valid`=1, commit the pending entry to the array.
  - If `mwp`=1 on the same edge, the old entry commits and the new one is captured; there is no stall and no loss.
  - `pend_valid` clears on an edge with `pend_valid`=1 and `mwp`=0.
- RUN, read path:
  - On an edge with `mrp`=1: `mmem` ← pending data if `pend_valid` and `pend_addr`==`madr`; otherwise `mmem` ← array[`madr`].
  - `mmem` holds its value when `mrp`=0.
- `mrp` and `mwp` high together (not produced by a legal state sequence, but defined):
  - the read uses the pre-edge view (array plus existing pending bypass);
  - the `mwp` value being captured on that edge is not visible to this read;
  - the write is captured normally.
- Reset asserted mid-INIT or mid-RUN: asynchronous abort; an uncommitted pending write is discarded; the sweep restarts from address 0 on release.
- Address arithmetic: `sweep_cnt` is AW+1 bits wide. Its MSB set terminates INIT, so there is no wrap back into the array.

## Timing
- Read latency: 1 clock. `mmem` reflects the addressed word after the edge sampling `mrp`.
- Write visibility:
  - Pending data is readable via bypass on the first edge after capture.
  - Array data is readable from the edge after commit onward.
  - A write followed by a read of the same address in the next cycle returns the new data.
- Back-to-back writes, one per cycle, are sustained indefinitely; the array commit rate is one per cycle.
- `init_busy` falls on the 32nd rising edge after `reset_n` rises. The first accepted `mrp`/`mwp` is on the following edge.
- No combinational path from inputs to `mmem` or `init_busy`.

## Structure
- Shared package holds: `MMEM_AW`, `MMEM_DW`, and the FSM state enum {INIT, RUN}.
- Sub-module `mmem_ram`:
  - 2^AW × DW array;
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port.
- The top level owns the FSM, sweep counter, pending register, bypass mux and output register.
- The write port mux selects the sweep (addr = `sweep_cnt`, data = 0) in INIT, and the pending entry in RUN.

## Test plan
- Reset release:
  - `init_busy` high for exactly 32 cycles;
  - afterwards, reads of addresses 0, 17 and 31 return 0x00000000;
  - `mwp` pulses issued during INIT leave no trace.
- Write 0xDEADBEEF to addr 5, read addr 5 next cycle → `mmem`=0xDEADBEEF via bypass; read again 3 cycles later → same value from the array.
- Back-to-back writes, addr 3 ← 0x11111111 then addr 3 ← 0x22222222, then a read of addr 3 → 0x22222222; addr 4 is still 0.
- Simultaneous `mrp`+`mwp` at addr 9 (array holds 0xA5A5A5A5, writing 0x5A5A5A5A) → `mmem`=0xA5A5A5A5; the next read → 0x5A5A5A5A.
- `mrp`=0 for 10 cycles with writes in flight → `mmem` holds the last read value unchanged.
- Reset pulsed for 1 cycle with a pending write to addr 7 (0x12345678) → after a fresh 32-cycle INIT, addr 7 reads 0.

Source files
------------

// File: rtl/mmem_port_pkg.sv
// Shared definitions for the M scratchpad memory port: geometry and FSM states.
package mmem_port_pkg;

   localparam int MMEM_AW = 5;
   localparam int MMEM_DW = 32;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } mmem_state_e;

endpackage

// File: rtl/mmem_port_ram.sv
// M scratchpad storage: 2^AW x DW array, one synchronous write port and one
// asynchronous read port. The array itself carries no reset; the port above
// zero-fills it after reset.
module mmem_ram #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Synchronous write, one word per clock.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mmem_port.sv
// M scratchpad memory port. After reset it sweeps zeros through the array,
// then serves reads (registered, 1-clock latency) and writes staged through a
// one-entry pending register that commits on the following edge. Reads of
// the pending address are served from the pending register.
module mmem_port
   import mmem_port_pkg::*;
#(
   parameter int AW = MMEM_AW,
   parameter int DW = MMEM_DW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] madr,
   input  logic          mrp,
   input  logic          mwp,
   input  logic [DW-1:0] l,
   output logic [DW-1:0] mmem,
   output logic          init_busy
);

   mmem_state_e   state;
   logic [AW:0]   sweep_cnt;
   logic [AW:0]   sweep_nxt;
   logic          pend_valid;
   logic [AW-1:0] pend_addr;
   logic [DW-1:0] pend_data;

   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          bypass_hit;

   assign sweep_nxt  = sweep_cnt + (AW+1)'(1);
   assign bypass_hit = pend_valid && (pend_addr == madr);

   // Write port mux: zero sweep during INIT, pending commit during RUN.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = pend_addr;
      ram_wdata = pend_data;
      if (state == INIT) begin
         ram_we    = 1'b1;
         ram_waddr = sweep_cnt[AW-1:0];
         ram_wdata = '0;
      end else begin
         ram_we    = pend_valid;
      end
   end

   mmem_ram #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (madr),
      .rdata (ram_rdata)
   );

   // Control FSM: sweep counter, pending valid flag and the registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= INIT;
         sweep_cnt  <= '0;
         pend_valid <= 1'b0;
         mmem       <= '0;
         init_busy  <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               sweep_cnt <= sweep_nxt;
               // Counter MSB marks the end of the sweep; no wrap into the array.
               if (sweep_nxt[AW]) begin
                  state     <= RUN;
                  init_busy <= 1'b0;
               end
            end
            RUN: begin
               // A new capture keeps the flag set while the old entry commits.
               pend_valid <= mwp;
               if (mrp) begin
                  mmem <= bypass_hit ? pend_data : ram_rdata;
               end
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

   // Pending entry payload; qualified by pend_valid so it needs no reset.
   always_ff @(posedge clk) begin
      if (state == RUN && mwp) begin
         pend_addr <= madr;
         pend_data <= l;
      end
   end

endmodule

// File: tb/tb_mmem_port.sv
// Self-checking bench for mmem_port: directed vector table, multi-cycle
// corner sequences and randomized traffic against a word-level memory model.
module tb_mmem_port;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk;
   logic          reset_n;
   logic [AW-1:0] madr;
   logic          mrp;
   logic          mwp;
   logic [DW-1:0] l;
   logic [DW-1:0] mmem;
   logic          init_busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: memory as the program sees it. A read observes every write
   // issued on an earlier edge; reset makes everything zero again.
   logic [DW-1:0] ref_mem [2**AW];
   logic [DW-1:0] exp_mmem;
   int            init_left;

   mmem_port #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .madr      (madr),
      .mrp       (mrp),
      .mwp       (mwp),
      .l         (l),
      .mmem      (mmem),
      .init_busy (init_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, compare both outputs.
   task automatic cycle(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      mrp  = r;
      mwp  = w;
      madr = a;
      l    = d;
      @(posedge clk);
      if (init_left > 0) begin
         init_left--;
      end else begin
         if (r) exp_mmem = ref_mem[a];
         if (w) ref_mem[a] = d;
      end
      #1;
      check("mmem", mmem, exp_mmem);
      check("init_busy", {31'd0, init_busy}, {31'd0, init_left > 0});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      mrp = 1'b0;
      mwp = 1'b0;
      #2;
      check("reset_mmem", mmem, '0);
      check("reset_init_busy", {31'd0, init_busy}, 32'd1);
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
      exp_mmem  = '0;
      init_left = 32;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Run INIT with write/read pulses that must be ignored; verify its length.
   task automatic run_init();
      int cnt;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!init_busy) break;
         cycle(1'($urandom), 1'b1, AW'(i), $urandom);
         cnt++;
      end
      check("init_cycles", cnt, 32);
   endtask

   typedef struct {
      logic          r;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs [16];
   logic [DW-1:0] held;

   initial begin
      reset_n = 1'b0;
      mrp = 1'b0;
      mwp = 1'b0;
      madr = '0;
      l = '0;

      vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h00000000};
      vecs[1]  = '{1'b1, 1'b0, 5'd17, 32'h0,        32'h00000000};
      vecs[2]  = '{1'b1, 1'b0, 5'd31, 32'h0,        32'h00000000};
      vecs[3]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h00000000};
      vecs[4]  = '{1'b1, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
      vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF};
      vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF};
      vecs[7]  = '{1'b1, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
      vecs[8]  = '{1'b0, 1'b1, 5'd3,  32'h11111111, 32'hDEADBEEF};
      vecs[9]  = '{1'b0, 1'b1, 5'd3,  32'h22222222, 32'hDEADBEEF};
      vecs[10] = '{1'b1, 1'b0, 5'd3,  32'h0,        32'h22222222};
      vecs[11] = '{1'b1, 1'b0, 5'd4,  32'h0,        32'h00000000};
      vecs[12] = '{1'b0, 1'b1, 5'd9,  32'hA5A5A5A5, 32'h00000000};
      vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'h00000000};
      vecs[14] = '{1'b1, 1'b1, 5'd9,  32'h5A5A5A5A, 32'hA5A5A5A5};
      vecs[15] = '{1'b1, 1'b0, 5'd9,  32'h0,        32'h5A5A5A5A};

      do_reset();
      run_init();

      // Directed vectors.
      for (int i = 0; i < 16; i++) begin
         cycle(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
         check($sformatf("vec%0d", i), mmem, vecs[i].exp);
      end

      // Reads idle for 10 cycles while writes stream in.
      held = mmem;
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, AW'(i), $urandom);
      check("hold_mmem", mmem, held);
      check("hold_value", held, 32'h5A5A5A5A);

      // Pending write discarded by a reset pulse.
      cycle(1'b0, 1'b1, 5'd7, 32'h12345678);
      do_reset();
      run_init();
      cycle(1'b1, 1'b0, 5'd7, 32'h0);
      check("addr7_after_reset", mmem, 32'h00000000);

      // Reset mid-INIT: sweep restarts and still lasts 32 cycles.
      cycle(1'b0, 1'b1, 5'd2, 32'hCAFEF00D);
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, AW'(i), $urandom);
      do_reset();
      run_init();

      // Randomized traffic on a narrow address window to exercise the bypass.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), $urandom);
      end
      for (int i = 0; i < 500; i++) begin
         cycle(1'($urandom), 1'($urandom), AW'($urandom), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
